// File: rtl/imem_pkg.sv
// Shared definitions for the instruction memory fetch unit: FSM encoding,
// the NOP word returned on faults and the even-parity helper.
package imem_pkg;

  typedef enum logic {
    ST_BOOT = 1'b0,
    ST_RUN  = 1'b1
  } imem_state_t;

  // All-zero word; callers narrow it to their DATA_W.
  localparam logic [63:0] NOP_WORD = 64'h0;

  // Returns the bit that makes {bit, d} contain an even number of ones.
  // Callers zero-extend their word to 64 bits, which leaves the result unchanged.
  function automatic logic even_parity(input logic [63:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/imem_array.sv
// Instruction storage: one write port and one synchronous read port.
// The read register only updates on re, so it holds the last word read.
module imem_array
  import imem_pkg::*;
#(
  parameter int W         = 16,
  parameter int DEPTH_LG2 = 6
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [DEPTH_LG2-1:0] waddr,
  input  logic [W-1:0]         wdata,
  input  logic                 re,
  input  logic [DEPTH_LG2-1:0] raddr,
  output logic [W-1:0]         rdata
);

  localparam int DEPTH = 1 << DEPTH_LG2;

  logic [W-1:0] mem [DEPTH];

  // No reset on the array or the read register: contents are reloaded after every reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/imem_fetch_unit.sv
// Instruction memory with boot load port and PC fetch handshake (1-cycle latency).
// Optional feature macro: IMEM_PARITY_EN adds a per-word even parity bit and a sticky parity_err.
module imem_fetch_unit
  import imem_pkg::*;
#(
  parameter int PC_W      = 32,
  parameter int DATA_W    = 16,
  parameter int DEPTH_LG2 = 6,
  parameter int BYTE_SH   = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 boot_we,
  input  logic [DEPTH_LG2-1:0] boot_addr,
  input  logic [DATA_W-1:0]    boot_data,
  input  logic                 boot_done,
  input  logic                 flush,
  input  logic                 fetch_req,
  input  logic [PC_W-1:0]      fetch_pc,
  output logic                 fetch_ready,
  output logic                 instr_valid,
  input  logic                 instr_ack,
  output logic [DATA_W-1:0]    instr_data,
  output logic [PC_W-1:0]      instr_pc,
  output logic                 instr_fault,
  output logic                 parity_err
);

`ifdef IMEM_PARITY_EN
  localparam int MEM_W = DATA_W + 1;
`else
  localparam int MEM_W = DATA_W;
`endif

  localparam logic [PC_W-1:0] ALIGN_MASK = PC_W'((64'd1 << BYTE_SH) - 64'd1);
  localparam logic [DATA_W-1:0] NOP = DATA_W'(NOP_WORD);

  imem_state_t          state, state_nxt;
  logic                 mem_we;
  logic [MEM_W-1:0]     mem_wdata;
  logic [MEM_W-1:0]     mem_rdata;
  logic [DATA_W-1:0]    rd_word;
  logic [DEPTH_LG2-1:0] rd_idx;
  logic                 misaligned;
  logic                 out_of_range;
  logic                 req_fault;
  logic                 accept;
  logic                 par_bad;
  logic                 valid_q;
  logic [PC_W-1:0]      pc_q;
  logic                 fault_q;

  // ---------------------------------------------------------------------------
  // FSM: BOOT accepts loader writes, RUN serves fetches.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_BOOT;
    end else begin
      state <= state_nxt;
    end
  end

  // Handshake: a fetch transfers on a rising edge where fetch_req & fetch_ready;
  // an instruction transfers where instr_valid & instr_ack. While instr_valid is
  // high and unacknowledged every instr_* output holds and no new fetch is taken.
  always_comb begin
    state_nxt   = state;
    fetch_ready = 1'b0;
    mem_we      = 1'b0;
    unique case (state)
      ST_BOOT: begin
        mem_we = boot_we;
        if (boot_done) begin
          state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        fetch_ready = ~flush & (~valid_q | instr_ack);
      end
      default: begin
        state_nxt = ST_BOOT;
      end
    endcase
  end

  assign accept = fetch_req & fetch_ready;

  // ---------------------------------------------------------------------------
  // Address check: upper PC bits only feed the range test.
  // ---------------------------------------------------------------------------
  assign misaligned   = (fetch_pc & ALIGN_MASK) != '0;
  assign out_of_range = (fetch_pc >> (BYTE_SH + DEPTH_LG2)) != '0;
  assign req_fault    = misaligned | out_of_range;
  assign rd_idx       = fetch_pc[BYTE_SH +: DEPTH_LG2];

  // ---------------------------------------------------------------------------
  // Storage and optional parity
  // ---------------------------------------------------------------------------
`ifdef IMEM_PARITY_EN
  logic par_sticky_q;

  assign mem_wdata = {even_parity(64'(boot_data)), boot_data};
  assign rd_word   = mem_rdata[DATA_W-1:0];
  // Only a word that was actually read can have a parity mismatch.
  assign par_bad   = valid_q & ~fault_q & (^mem_rdata);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      par_sticky_q <= 1'b0;
    end else if (par_bad) begin
      par_sticky_q <= 1'b1;
    end
  end

  assign parity_err = par_sticky_q | par_bad;
`else
  assign mem_wdata  = boot_data;
  assign rd_word    = mem_rdata;
  assign par_bad    = 1'b0;
  assign parity_err = 1'b0;
`endif

  imem_array #(
    .W         (MEM_W),
    .DEPTH_LG2 (DEPTH_LG2)
  ) u_array (
    .clk   (clk),
    .we    (mem_we),
    .waddr (boot_addr),
    .wdata (mem_wdata),
    .re    (accept & ~req_fault),
    .raddr (rd_idx),
    .rdata (mem_rdata)
  );

  // ---------------------------------------------------------------------------
  // Output register: the RAM read register supplies the data, these carry the
  // rest of the word's sideband.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      pc_q    <= '0;
      fault_q <= 1'b0;
    end else if (accept) begin
      valid_q <= 1'b1;
      pc_q    <= fetch_pc;
      fault_q <= req_fault;
    end else if (flush | instr_ack) begin
      valid_q <= 1'b0;
    end
  end

  assign instr_valid = valid_q;
  assign instr_pc    = pc_q;
  assign instr_fault = fault_q | par_bad;
  // Gating with valid keeps data at NOP out of reset, when the RAM register is undefined.
  assign instr_data  = (valid_q & ~fault_q & ~par_bad) ? rd_word : NOP;

endmodule
